// File: rtl/vend_ctrl_multi.sv
// vend_ctrl_multi: multi-item vending controller.
// Takes front-panel inputs (start, cancel, keypad, coin acceptor, IR drop
// sensor) and drives the motor, LEDs, buzzer, change hopper and fault flag.
// Every output is a register. The state output tracks the state register
// directly; all other outputs reflect the state of the previous cycle.
// Optional build macro: STOCK_COUNT_EN adds per-item stock counters,
// restock ports and a sold_out pulse. Without it, stock is unlimited.

module vend_ctrl_multi #(
    parameter int N_ITEMS       = 8,
    parameter int CREDIT_W      = 8,
    parameter int TIMEOUT_CYC   = 1000,
    parameter int MOTOR_MAX_CYC = 500,
    parameter int BUZZ_CYC      = 4,
    localparam int SEL_W        = $clog2(N_ITEMS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        cancel,
    input  logic                        key_valid,
    input  logic [SEL_W-1:0]            key_code,
    input  logic                        coin_valid,
    input  logic [CREDIT_W-1:0]         coin_value,
    input  logic [N_ITEMS*CREDIT_W-1:0] prices,
    input  logic                        ir_sensor,
    output logic [2:0]                  state,
    output logic                        red_led,
    output logic [2:0]                  green_leds,
    output logic                        motor_en,
    output logic [SEL_W-1:0]            motor_sel,
    output logic                        buzzer,
    output logic                        change_valid,
    output logic [CREDIT_W-1:0]         change_amount,
    output logic                        fault
`ifdef STOCK_COUNT_EN
    ,
    input  logic                        restock,
    input  logic [SEL_W-1:0]            restock_item,
    input  logic [7:0]                  restock_qty,
    output logic                        sold_out
`endif
);

    // state    | meaning
    // IDLE     | waiting for start, red LED on, coins ignored
    // SELECT   | waiting for a valid product key, coins credited
    // PAYMENT  | collecting credit until it covers the selected price
    // DISPENSE | motor running until the IR sensor sees the product drop
    // COMPLETE | buzzer on for BUZZ_CYC cycles, change paid on first cycle
    // REFUND   | single cycle returning any credit
    // FAULT    | motor jam; sticky until reset, credit kept
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SELECT   = 3'd1,
        PAYMENT  = 3'd2,
        DISPENSE = 3'd3,
        COMPLETE = 3'd4,
        REFUND   = 3'd5,
        FAULT    = 3'd6
    } state_t;

    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int MOT_W = (MOTOR_MAX_CYC > 1) ? $clog2(MOTOR_MAX_CYC) : 1;
    localparam int BUZ_W = (BUZZ_CYC > 1) ? $clog2(BUZZ_CYC) : 1;

    localparam logic [TMR_W-1:0] TMR_LOAD    = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [MOT_W-1:0] MOT_LOAD    = MOT_W'(MOTOR_MAX_CYC - 1);
    localparam logic [BUZ_W-1:0] BUZ_LOAD    = BUZ_W'(BUZZ_CYC - 1);
    localparam logic [SEL_W:0]   N_ITEMS_EXT = (SEL_W + 1)'(N_ITEMS);

    state_t              st;
    logic [CREDIT_W-1:0] credit;
    logic [SEL_W-1:0]    sel;
    logic [TMR_W-1:0]    idle_tmr;
    logic [MOT_W-1:0]    motor_tmr;
    logic [BUZ_W-1:0]    buzz_tmr;

    logic [CREDIT_W-1:0] price_sel;
    logic [CREDIT_W-1:0] coin_add;
    logic                key_in_range;
    logic                key_take;
    logic                any_event;

    // Adds two credit values, clamping at the all-ones maximum.
    function automatic logic [CREDIT_W-1:0] sat_add(input logic [CREDIT_W-1:0] a,
                                                    input logic [CREDIT_W-1:0] b);
        logic [CREDIT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[CREDIT_W])
            sat_add = '1;
        else
            sat_add = s[CREDIT_W-1:0];
    endfunction

    assign state        = st;
    assign price_sel    = prices[int'(sel) * CREDIT_W +: CREDIT_W];
    assign coin_add     = coin_valid ? coin_value : '0;
    assign key_in_range = ({1'b0, key_code} < N_ITEMS_EXT);
    assign any_event    = key_valid || coin_valid;

`ifdef STOCK_COUNT_EN
    logic [7:0] stock [N_ITEMS];
    logic       key_sold_out;
    logic       dispense_done;

    // Adds a restock quantity (saturating at 255) after removing one
    // dispensed unit.
    function automatic logic [7:0] stock_update(input logic [7:0] cur,
                                                input logic       dec,
                                                input logic       add,
                                                input logic [7:0] qty);
        logic [7:0] base;
        logic [8:0] s;
        base = (dec && cur != 8'd0) ? cur - 8'd1 : cur;
        s    = {1'b0, base} + {1'b0, (add ? qty : 8'd0)};
        if (s[8])
            stock_update = 8'hFF;
        else
            stock_update = s[7:0];
    endfunction

    assign key_take      = key_valid && key_in_range && (stock[key_code] != 8'd0);
    assign key_sold_out  = key_valid && key_in_range && (stock[key_code] == 8'd0);
    assign dispense_done = (st == DISPENSE) && ir_sensor;

    // Per-item stock: restock in any state, one unit removed on each drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_ITEMS; i++)
                stock[i] <= 8'd0;
        end else begin
            for (int i = 0; i < N_ITEMS; i++)
                stock[i] <= stock_update(stock[i],
                                         dispense_done && (sel == SEL_W'(i)),
                                         restock && (restock_item == SEL_W'(i)),
                                         restock_qty);
        end
    end
`else
    assign key_take = key_valid && key_in_range;
`endif

    // Main sequencing FSM with credit, timers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st            <= IDLE;
            credit        <= '0;
            sel           <= '0;
            idle_tmr      <= '0;
            motor_tmr     <= '0;
            buzz_tmr      <= '0;
            red_led       <= 1'b1;
            green_leds    <= 3'b000;
            motor_en      <= 1'b0;
            motor_sel     <= '0;
            buzzer        <= 1'b0;
            change_valid  <= 1'b0;
            change_amount <= '0;
            fault         <= 1'b0;
`ifdef STOCK_COUNT_EN
            sold_out      <= 1'b0;
`endif
        end else begin
            red_led      <= 1'b0;
            green_leds   <= 3'b000;
            motor_en     <= 1'b0;
            motor_sel    <= sel;
            buzzer       <= 1'b0;
            change_valid <= 1'b0;
`ifdef STOCK_COUNT_EN
            sold_out     <= 1'b0;
`endif
            case (st)
                IDLE: begin
                    red_led <= 1'b1;
                    if (start) begin
                        st       <= SELECT;
                        idle_tmr <= TMR_LOAD;
                    end
                end

                SELECT: begin
                    green_leds <= 3'b001;
                    credit     <= sat_add(credit, coin_add);
                    if (any_event)
                        idle_tmr <= TMR_LOAD;
                    else if (idle_tmr != '0)
                        idle_tmr <= idle_tmr - 1'b1;
                    if (cancel) begin
                        st <= REFUND;
                    end else if (key_take) begin
                        sel      <= key_code;
                        st       <= PAYMENT;
                        idle_tmr <= TMR_LOAD;
                    end else if (!any_event && idle_tmr == '0) begin
                        st <= REFUND;
                    end
`ifdef STOCK_COUNT_EN
                    if (!cancel && key_sold_out)
                        sold_out <= 1'b1;
`endif
                end

                PAYMENT: begin
                    green_leds <= 3'b011;
                    if (any_event)
                        idle_tmr <= TMR_LOAD;
                    else if (idle_tmr != '0)
                        idle_tmr <= idle_tmr - 1'b1;
                    if (cancel) begin
                        credit <= sat_add(credit, coin_add);
                        st     <= REFUND;
                    end else if (credit >= price_sel) begin
                        // A coin landing on the purchase cycle stays as credit.
                        credit    <= sat_add(credit - price_sel, coin_add);
                        motor_tmr <= MOT_LOAD;
                        st        <= DISPENSE;
                    end else begin
                        credit <= sat_add(credit, coin_add);
                        if (key_take)
                            sel <= key_code;
                        else if (!any_event && idle_tmr == '0)
                            st <= REFUND;
`ifdef STOCK_COUNT_EN
                        if (key_sold_out)
                            sold_out <= 1'b1;
`endif
                    end
                end

                DISPENSE: begin
                    motor_en   <= 1'b1;
                    green_leds <= 3'b111;
                    if (ir_sensor) begin
                        buzz_tmr <= BUZ_LOAD;
                        st       <= COMPLETE;
                    end else if (motor_tmr == '0) begin
                        st <= FAULT;
                    end else begin
                        motor_tmr <= motor_tmr - 1'b1;
                    end
                end

                COMPLETE: begin
                    buzzer     <= 1'b1;
                    green_leds <= 3'b111;
                    if (buzz_tmr == BUZ_LOAD && credit != '0) begin
                        change_valid  <= 1'b1;
                        change_amount <= credit;
                    end
                    credit <= '0;
                    if (buzz_tmr == '0)
                        st <= IDLE;
                    else
                        buzz_tmr <= buzz_tmr - 1'b1;
                end

                REFUND: begin
                    if (credit != '0) begin
                        change_valid  <= 1'b1;
                        change_amount <= credit;
                    end
                    credit <= '0;
                    st     <= IDLE;
                end

                FAULT: begin
                    fault   <= 1'b1;
                    red_led <= 1'b1;
                end

                default: begin
                    st <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Testbench for vend_ctrl_multi: directed scenarios plus random traffic,
// compared cycle by cycle with a behavioural model of the vending rules.

module tb_vend_ctrl_multi;

    localparam int N    = 6;
    localparam int CW   = 8;
    localparam int TO   = 16;
    localparam int MM   = 20;
    localparam int BZ   = 4;
    localparam int SW   = 3;
    localparam int CMAX = 255;

    localparam int S_IDLE = 0, S_SELECT = 1, S_PAYMENT = 2, S_DISPENSE = 3;
    localparam int S_COMPLETE = 4, S_REFUND = 5, S_FAULT = 6;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              cancel = 1'b0;
    logic              key_valid = 1'b0;
    logic [SW-1:0]     key_code = '0;
    logic              coin_valid = 1'b0;
    logic [CW-1:0]     coin_value = '0;
    logic [N*CW-1:0]   prices;
    logic              ir_sensor = 1'b0;
    logic [2:0]        state;
    logic              red_led;
    logic [2:0]        green_leds;
    logic              motor_en;
    logic [SW-1:0]     motor_sel;
    logic              buzzer;
    logic              change_valid;
    logic [CW-1:0]     change_amount;
    logic              fault;

    int price_tab [N] = '{15, 30, 50, 100, 200, 255};
    int coin_tab  [7] = '{1, 5, 10, 20, 25, 50, 100};

    int n_checks = 0;
    int n_pass   = 0;

    // model state
    int ms, mcredit, msel, midle, mmot, mbuzz;
    int e_red, e_green, e_men, e_msel, e_buzz, e_cv, e_ca, e_fault;

    // observation counters
    int n_chg = 0, last_chg = -1, n_buzz = 0, last_msel = -1, saw_fault = 0;
    int c0, b0;

    always #5 clk = ~clk;

    vend_ctrl_multi #(
        .N_ITEMS(N), .CREDIT_W(CW), .TIMEOUT_CYC(TO),
        .MOTOR_MAX_CYC(MM), .BUZZ_CYC(BZ)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cancel(cancel),
        .key_valid(key_valid), .key_code(key_code),
        .coin_valid(coin_valid), .coin_value(coin_value),
        .prices(prices), .ir_sensor(ir_sensor),
        .state(state), .red_led(red_led), .green_leds(green_leds),
        .motor_en(motor_en), .motor_sel(motor_sel), .buzzer(buzzer),
        .change_valid(change_valid), .change_amount(change_amount),
        .fault(fault)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic model_reset();
        ms = S_IDLE; mcredit = 0; msel = 0; midle = 0; mmot = 0; mbuzz = 0;
        e_red = 1; e_green = 0; e_men = 0; e_msel = 0; e_buzz = 0;
        e_cv = 0; e_ca = 0; e_fault = 0;
    endtask

    // One clock of the vending rules. Visible outputs follow the state the
    // machine was in during this cycle; the state itself moves on now.
    task automatic model_step(input int s, input int cn, input int kv, input int kc,
                              input int cv, input int cval, input int ir);
        int coin;
        int price;
        bit key_ok;
        bit evt;
        coin   = (cv != 0) ? cval : 0;
        price  = price_tab[msel];
        key_ok = (kv != 0) && (kc < N);
        evt    = (kv != 0) || (cv != 0);

        e_red   = (ms == S_IDLE || ms == S_FAULT) ? 1 : 0;
        e_green = (ms == S_SELECT) ? 1 : (ms == S_PAYMENT) ? 3 :
                  (ms == S_DISPENSE || ms == S_COMPLETE) ? 7 : 0;
        e_men   = (ms == S_DISPENSE) ? 1 : 0;
        e_msel  = msel;
        e_buzz  = (ms == S_COMPLETE) ? 1 : 0;
        e_fault = (e_fault != 0 || ms == S_FAULT) ? 1 : 0;
        e_cv    = 0;

        case (ms)
            S_IDLE: if (s != 0) begin ms = S_SELECT; midle = 0; end
            S_SELECT: begin
                mcredit = sat(mcredit + coin);
                if (cn != 0) ms = S_REFUND;
                else if (key_ok) begin msel = kc; ms = S_PAYMENT; midle = 0; end
                else if (evt) midle = 0;
                else if (midle == TO - 1) ms = S_REFUND;
                else midle++;
            end
            S_PAYMENT: begin
                if (cn != 0) begin
                    mcredit = sat(mcredit + coin); ms = S_REFUND;
                end else if (mcredit >= price) begin
                    mcredit = sat(mcredit - price + coin); ms = S_DISPENSE; mmot = 0;
                end else begin
                    mcredit = sat(mcredit + coin);
                    if (evt) begin
                        midle = 0;
                        if (key_ok) msel = kc;
                    end else if (midle == TO - 1) ms = S_REFUND;
                    else midle++;
                end
            end
            S_DISPENSE: begin
                if (ir != 0) begin ms = S_COMPLETE; mbuzz = 0; end
                else if (mmot == MM - 1) ms = S_FAULT;
                else mmot++;
            end
            S_COMPLETE: begin
                if (mbuzz == 0 && mcredit > 0) begin e_cv = 1; e_ca = mcredit; end
                mcredit = 0;
                if (mbuzz == BZ - 1) ms = S_IDLE; else mbuzz++;
            end
            S_REFUND: begin
                if (mcredit > 0) begin e_cv = 1; e_ca = mcredit; end
                mcredit = 0;
                ms = S_IDLE;
            end
            default: ;
        endcase
    endtask

    task automatic compare_outputs();
        check("state", int'(state), ms);
        check("red_led", int'(red_led), e_red);
        check("green_leds", int'(green_leds), e_green);
        check("motor_en", int'(motor_en), e_men);
        if (e_men != 0) check("motor_sel", int'(motor_sel), e_msel);
        check("buzzer", int'(buzzer), e_buzz);
        check("change_valid", int'(change_valid), e_cv);
        if (e_cv != 0) check("change_amount", int'(change_amount), e_ca);
        check("fault", int'(fault), e_fault);
    endtask

    task automatic observe();
        if (change_valid) begin n_chg++; last_chg = int'(change_amount); end
        if (buzzer) n_buzz++;
        if (motor_en) last_msel = int'(motor_sel);
        if (fault) saw_fault = 1;
    endtask

    task automatic tick(input int s, input int cn, input int kv, input int kc,
                        input int cv, input int cval, input int ir);
        @(negedge clk);
        compare_outputs();
        observe();
        start      = s[0];
        cancel     = cn[0];
        key_valid  = kv[0];
        key_code   = kc[SW-1:0];
        coin_valid = cv[0];
        coin_value = cval[CW-1:0];
        ir_sensor  = ir[0];
        model_step(s, cn, kv, kc, cv, cval, ir);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        compare_outputs();
        observe();
        start = 0; cancel = 0; key_valid = 0; coin_valid = 0; ir_sensor = 0;
        #2 reset = 1'b1;
        #1;
        check("rst_state", int'(state), S_IDLE);
        check("rst_red_led", int'(red_led), 1);
        check("rst_change_valid", int'(change_valid), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_motor_en", int'(motor_en), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        model_step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) prices[i*CW +: CW] = price_tab[i][CW-1:0];
        model_reset();
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        compare_outputs();
        reset = 1'b0;
        model_step(0, 0, 0, 0, 0, 0, 0);

        // key 2 (50), coins 20,20,20 -> dispense, change 10, buzzer 4 cycles
        c0 = n_chg; b0 = n_buzz;
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 2, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 20, 0);
        tick(0, 0, 0, 0, 1, 20, 0);
        tick(0, 0, 0, 0, 1, 20, 0);
        idle(3);
        tick(0, 0, 0, 0, 0, 0, 1);
        idle(7);
        check("s1_chg_count", n_chg - c0, 1);
        check("s1_chg_amount", last_chg, 10);
        check("s1_buzz_cycles", n_buzz - b0, 4);
        check("s1_motor_sel", last_msel, 2);

        // exact payment on item 1 (30): no change strobe
        c0 = n_chg; b0 = n_buzz;
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 1, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 10, 0);
        tick(0, 0, 0, 0, 1, 20, 0);
        idle(2);
        tick(0, 0, 0, 0, 0, 0, 1);
        idle(7);
        check("s2_chg_count", n_chg - c0, 0);
        check("s2_buzz_cycles", n_buzz - b0, 4);

        // coin in IDLE ignored; 25+10 then cancel with a 5 coin -> refund 40
        c0 = n_chg;
        tick(0, 0, 0, 0, 1, 50, 0);
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 3, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 25, 0);
        tick(0, 0, 0, 0, 1, 10, 0);
        tick(0, 1, 0, 0, 1, 5, 0);
        idle(3);
        check("s3_chg_count", n_chg - c0, 1);
        check("s3_chg_amount", last_chg, 40);

        // inactivity timeout in PAYMENT refunds 5, in SELECT refunds nothing
        c0 = n_chg;
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 1, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 5, 0);
        idle(TO + 3);
        check("s4_chg_count", n_chg - c0, 1);
        check("s4_chg_amount", last_chg, 5);
        c0 = n_chg;
        tick(1, 0, 0, 0, 0, 0, 0);
        idle(TO + 3);
        check("s4_select_timeout_chg", n_chg - c0, 0);

        // motor jam -> FAULT, start ignored, reset clears, held credit lost
        c0 = n_chg; saw_fault = 0;
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 20, 0);
        idle(MM + 3);
        tick(1, 0, 0, 0, 0, 0, 0);
        idle(3);
        check("s5_fault_seen", saw_fault, 1);
        do_reset();
        idle(2);
        check("s5_chg_count", n_chg - c0, 0);

        // saturation at 255, out-of-range keys ignored, cancel refunds 255
        c0 = n_chg;
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 100, 0);
        tick(0, 0, 0, 0, 1, 100, 0);
        tick(0, 0, 0, 0, 1, 100, 0);
        tick(0, 0, 1, 6, 0, 0, 0);
        tick(0, 0, 1, 7, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0, 0);
        idle(3);
        check("s6_chg_count", n_chg - c0, 1);
        check("s6_chg_amount", last_chg, 255);

        // reset in the middle of a payment: credit dropped silently
        c0 = n_chg;
        tick(1, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 3, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 50, 0);
        tick(0, 0, 0, 0, 1, 20, 0);
        do_reset();
        idle(4);
        check("s7_chg_count", n_chg - c0, 0);

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ((ms == S_FAULT && $urandom_range(0, 7) == 0) || $urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                tick(($urandom_range(0, 3) == 0) ? 1 : 0,
                     ($urandom_range(0, 39) == 0) ? 1 : 0,
                     ($urandom_range(0, 9) == 0) ? 1 : 0,
                     int'($urandom_range(0, 7)),
                     ($urandom_range(0, 4) == 0) ? 1 : 0,
                     coin_tab[$urandom_range(0, 6)],
                     ($urandom_range(0, 5) == 0) ? 1 : 0);
            end
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vend_ctrl_multi.md
Name: vend_ctrl_multi

Overview:
- Parametrised vending-machine controller; successor to the single-item pushbutton/keypad FSM.
- Supports N_ITEMS products with per-item prices, coin credit accumulation, change return, cancel/refund, inactivity timeout and a motor-jam watchdog.
- Sits between front-panel I/O (button, keypad, coin acceptor, IR drop sensor) and actuators (motor, LEDs, buzzer, change hopper).

Parameters:
- N_ITEMS, 8, number of selectable products (2..16); SEL_W = $clog2(N_ITEMS).
- CREDIT_W, 8, width of credit, price and coin values (unsigned).
- TIMEOUT_CYC, 1000, idle cycles in SELECT/PAYMENT before refund.
- MOTOR_MAX_CYC, 500, max DISPENSE cycles without IR before fault.
- BUZZ_CYC, 4, cycles buzzer held in COMPLETE.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  pushbutton, level; acted on only in IDLE
- cancel  in  1  abort request, acted on in SELECT/PAYMENT
- key_valid  in  1  one-cycle strobe, key_code valid
- key_code  in  SEL_W  product index
- coin_valid  in  1  one-cycle strobe, coin_value valid
- coin_value  in  CREDIT_W  coin value
- prices  in  N_ITEMS*CREDIT_W  packed price table, item i at [i*CREDIT_W +: CREDIT_W]; quasi-static
- ir_sensor  in  1  product-drop detect
- state  out  3  current state encoding
- red_led  out  1  idle indicator
- green_leds  out  3  progress indicator
- motor_en  out  1  dispense motor drive
- motor_sel  out  SEL_W  latched selection
- buzzer  out  1  completion tone
- change_valid  out  1  one-cycle strobe
- change_amount  out  CREDIT_W  change/refund value, valid with change_valid
- fault  out  1  sticky motor-jam flag

Behaviour:
- State encoding: IDLE=0, SELECT=1, PAYMENT=2, DISPENSE=3, COMPLETE=4, REFUND=5, FAULT=6. All outputs registered (Moore, 1-cycle latency from state change).
- Reset: state IDLE, credit 0, sel 0, timers 0; outputs 0 except red_led=1; fault=0.
- IDLE: red_led=1. start -> SELECT. Coins in IDLE are ignored (not credited).
- SELECT: green_leds=001. key_valid with key_code<N_ITEMS -> latch sel, -> PAYMENT. key_code>=N_ITEMS ignored. Coins accepted and credited here too.
- PAYMENT: green_leds=011. coin_valid adds coin_value to credit, saturating at 2^CREDIT_W-1. When credit >= prices[sel] (checked on registered credit) -> DISPENSE; credit -= price in the same transition. key_valid in PAYMENT re-latches sel (reselection allowed).
- Inactivity timer: reset to 0 on entering SELECT/PAYMENT and on any key_valid/coin_valid; reaching TIMEOUT_CYC-1 -> REFUND.
- cancel in SELECT/PAYMENT -> REFUND. cancel has priority over coin/key on the same cycle; a simultaneous coin is still credited before refund.
- DISPENSE: motor_en=1, motor_sel=sel, green_leds=111. ir_sensor high -> COMPLETE. Counter reaching MOTOR_MAX_CYC-1 without IR -> FAULT. Coins ignored.
- COMPLETE: buzzer=1 for BUZZ_CYC cycles; on the first cycle, if credit>0, change_valid=1 with change_amount=credit. credit cleared; -> IDLE after BUZZ_CYC.
- REFUND: one cycle; change_valid=1, change_amount=credit if credit>0 (no strobe if 0); credit cleared; -> IDLE.
- FAULT: fault=1, red_led=1, motor off; credit held (not refunded); exit only by reset.
- Reset asserted mid-operation: immediate return to reset values; credit lost, no change strobe.

Optional Feature:
- STOCK_COUNT_EN: defined -> per-item stock counters (8 bits each, reset to 0), an extra input restock (1) with restock_item (SEL_W) and restock_qty (8) adds saturating qty in any state, and an extra output sold_out (1). A key_valid for an item with stock 0 is rejected: stay in state, sold_out pulses one cycle. Stock decrements on the DISPENSE->COMPLETE transition. Undefined -> infinite stock; no restock ports; sold_out absent.

Test Plan:
- Reset, start, key 2 (price 50), coins 20,20,20 -> DISPENSE after third coin, motor_sel=2; IR -> COMPLETE, change_valid with 10, buzzer 4 cycles, IDLE.
- Exact pay: price 30, coins 10,20 -> DISPENSE, no change_valid strobe in COMPLETE.
- Coins 25,10, then cancel with simultaneous coin 5 -> REFUND, change_amount=40, IDLE next.
- TIMEOUT_CYC=16: key 1, coin 5, idle 16 cycles -> REFUND change 5; SELECT with no credit times out with no change strobe.
- DISPENSE with IR held low MOTOR_MAX_CYC cycles -> FAULT, fault=1, motor_en=0; start ignored; reset clears.
- CREDIT_W=8: coins totalling 300 saturate credit at 255; key_code=N_ITEMS ignored in SELECT.
